aes_ct_uart_tx: RTL

Downstream stage of `aes_core`: captures each 128-bit ciphertext block on the core's `done` pulse and serialises it as 16 UART 8N1 frames on a single `tx` line. The block is the transmit half of the serial security wrapper. It holds one block in flight plus one queued block, so the AES core can start the next encryption while the current one drains. Blocks offered with no free slot are dropped and flagged.

---
 rtl/aes_link_pkg.sv | 16 +
 rtl/aes_ct_uart_tx_if.sv | 22 ++
 rtl/uart_byte_tx.sv | 113 +++++++++++
 rtl/aes_ct_uart_tx.sv | 108 ++++++++++
 4 files changed

// File: rtl/aes_link_pkg.sv
// Shared constants and types for the AES ciphertext serial link.
// Block geometry, baud default and the byte-engine state encoding.
package aes_link_pkg;

   localparam int BLK_BITS         = 128;
   localparam int BLK_BYTES        = 16;
   localparam int CLKS_PER_BIT_DEF = 868;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

endpackage

// File: rtl/aes_ct_uart_tx_if.sv
// Block offer handshake between the AES core and the UART transmitter.
// The source presents a one-cycle valid with data; the sink reports ready.
interface aes_ct_uart_tx_if;
   import aes_link_pkg::*;

   logic                blk_valid;
   logic [BLK_BITS-1:0] blk_data;
   logic                blk_ready;

   modport master (
      output blk_valid,
      output blk_data,
      input  blk_ready
   );

   modport slave (
      input  blk_valid,
      input  blk_data,
      output blk_ready
   );

endinterface

// File: rtl/uart_byte_tx.sv
// One 8N1 UART byte: baud counter plus start/data/stop sequencing.
// byte_done marks the last cycle of the stop bit so a next byte can follow.
module uart_byte_tx
   import aes_link_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       byte_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

   tx_state_e     state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          bit_end;

   assign bit_end   = (baud_q == BAUD_MAX);
   assign byte_done = (state_q == STOP) && bit_end;
   assign tx        = tx_q;
   assign busy      = busy_q;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = START;
               baud_d  = '0;
               sh_d    = data;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               baud_d  = '0;
               bit_d   = 3'd0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  bit_d   = 3'd0;
               end else begin
                  bit_d = bit_q + 3'd1;
                  sh_d  = {1'b0, sh_q[7:1]};
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               // Back-to-back bytes: reload on the stop bit's final edge.
               if (start) begin
                  state_d = START;
                  sh_d    = data;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sh_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         sh_q    <= 8'h00;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: rtl/aes_ct_uart_tx.sv
// Serialises 128-bit AES ciphertext blocks as 16 UART 8N1 frames.
// One block shifts out while a second waits in the hold register.
module aes_ct_uart_tx
   import aes_link_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   aes_ct_uart_tx_if.slave  blk,
   output logic             tx,
   output logic             busy,
   output logic             tx_done,
   output logic             overrun
);

   localparam int IW = $clog2(BLK_BYTES);

   logic [BLK_BITS-1:0] shift_q, shift_d;
   logic [BLK_BITS-1:0] hold_q, hold_d;
   logic                hold_full_q, hold_full_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                done_q, done_d;
   logic                ovr_q, ovr_d;
   logic                eng_start;
   logic [7:0]          eng_data;
   logic                byte_done;
   logic                last;
   logic                acc;

   assign blk.blk_ready = !hold_full_q;
   assign tx_done       = done_q;
   assign overrun       = ovr_q;

   uart_byte_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .clk       (clk),
      .rst       (rst),
      .start     (eng_start),
      .data      (eng_data),
      .tx        (tx),
      .busy      (busy),
      .byte_done (byte_done)
   );

   always_comb begin
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      idx_d       = idx_q;
      done_d      = 1'b0;
      eng_start   = 1'b0;
      last        = byte_done && (idx_q == IW'(BLK_BYTES - 1));
      // A full hold frees up on the block-end edge, so that offer is taken.
      acc         = blk.blk_valid && (!hold_full_q || last);
      ovr_d       = ovr_q || (blk.blk_valid && !acc);

      if (!busy) begin
         if (acc) begin
            shift_d   = blk.blk_data;
            idx_d     = '0;
            eng_start = 1'b1;
         end
      end else if (last) begin
         done_d = 1'b1;
         idx_d  = '0;
         if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            eng_start   = 1'b1;
         end else if (acc) begin
            shift_d   = blk.blk_data;
            eng_start = 1'b1;
         end
      end else if (byte_done) begin
         shift_d   = {shift_q[BLK_BITS-9:0], 8'h00};
         idx_d     = idx_q + 1'b1;
         eng_start = 1'b1;
      end

      if (acc && busy && !(last && !hold_full_q)) begin
         hold_d      = blk.blk_data;
         hold_full_d = 1'b1;
      end

      eng_data = shift_d[BLK_BITS-1 -: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         idx_q       <= '0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         idx_q       <= idx_d;
         done_q      <= done_d;
         ovr_q       <= ovr_d;
      end
   end

endmodule
